fault_response_fsm: RTL and testbench
=====================================

FAULT_RESPONSE_FSM -- requirements
Module: fault_response_fsm

Interface
REQ-001 The block SHALL have parameter FLUSH_CYCLES, default 3, meaning the number of cycles flush is held per MINOR fault (legal range 1..15).
REQ-002 The block SHALL have parameter MAX_RETRY, default 2, meaning the number of consecutive MINOR retries allowed before escalation (legal range 1..15).
REQ-003 The block SHALL have parameter CNT_W, default 8, meaning the width of each event counter.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 The block SHALL have port fault_type, input, 2, the classifier output: 00 NONE, 01 MINOR, 10 CRITICAL, 11 reserved.
REQ-007 The block SHALL have port instr_retired, input, 1, a pulse marking a successful instruction commit.
REQ-008 The block SHALL have port clear_fault, input, 1, a debug/software release of HALT.
REQ-009 The block SHALL have port stall, output, 1, freezing the fetch and decode stages.
REQ-010 The block SHALL have port flush, output, 1, invalidating in-flight pipeline instructions.
REQ-011 The block SHALL have port retry, output, 1, a 1-cycle pulse that re-fetches the faulting PC.
REQ-012 The block SHALL have port halted, output, 1, meaning the core is halted on a fault.
REQ-013 The block SHALL have port fault_irq, output, 1, a 1-cycle pulse on HALT entry.
REQ-014 The block SHALL have port state, output, 2, the current FSM state.
REQ-015 The block SHALL have port minor_cnt, output, CNT_W, the accepted MINOR events.
REQ-016 The block SHALL have port critical_cnt, output, CNT_W, the HALT entries.

Function
REQ-017 The FSM SHALL have four states with these encodings: IDLE=00, FLUSH=01, RETRY=10, HALT=11.
REQ-018 All outputs SHALL be registered or decoded from registered state only, so the response appears exactly 1 cycle after fault_type is sampled.
REQ-019 IDLE: with fault_type=10 or 11, the next state SHALL be HALT.
REQ-020 IDLE: with fault_type=01 and retry_cnt<MAX_RETRY, the next state SHALL be FLUSH, with flush_ctr loaded to FLUSH_CYCLES-1, retry_cnt incremented and minor_cnt incremented.
REQ-021 IDLE: with fault_type=01 and retry_cnt==MAX_RETRY, the block SHALL escalate to HALT, increment minor_cnt and leave retry_cnt unchanged.
REQ-022 IDLE: with fault_type=00 and instr_retired=1, retry_cnt SHALL clear to 0; a fault and instr_retired in the same cycle SHALL follow the fault rules, and retry_cnt SHALL not clear.
REQ-023 FLUSH: stall=1 and flush=1; flush_ctr SHALL decrement each cycle, and when flush_ctr==0 the next state SHALL be RETRY.
REQ-024 FLUSH: fault_type=10/11 SHALL go to HALT on the next edge, abandoning the flush; fault_type=01 SHALL be ignored, not counted and with no state effect.
REQ-025 RETRY: stall=1, retry=1 and flush=0 for exactly one cycle; the next state SHALL be IDLE unconditionally, with faults that cycle ignored.
REQ-026 HALT: stall=1 and halted=1, all fault_type and instr_retired SHALL be ignored, and the state SHALL remain HALT until clear_fault=1.
REQ-027 HALT with clear_fault=1: the next state SHALL be IDLE and retry_cnt SHALL clear to 0; clear_fault SHALL be ignored in all other states.
REQ-028 Every transition into HALT SHALL increment critical_cnt once and pulse fault_irq=1 for the first HALT cycle only.
REQ-029 IDLE outputs SHALL be stall=0, flush=0, retry=0 and halted=0.
REQ-030 minor_cnt and critical_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-031 retry_cnt SHALL be internal, with width sufficient for MAX_RETRY, and never exceed MAX_RETRY.

Reset
REQ-032 While rst_n=0, the block SHALL asynchronously force state=IDLE, stall=0, flush=0, retry=0, halted=0, fault_irq=0, minor_cnt=0, critical_cnt=0, retry_cnt=0 and flush_ctr=0.
REQ-033 Reset asserted mid-FLUSH or mid-HALT SHALL abort immediately, with no retry pulse and no fault_irq generated.
REQ-034 After rst_n deasserts, the first fault_type sample SHALL occur on the next rising edge.

Verification
REQ-035 The bench SHALL drive fault_type=01 for 1 cycle in IDLE and require: flush=1 for 3 cycles, then retry=1 for 1 cycle, then IDLE, with minor_cnt=1.
REQ-036 The bench SHALL drive three isolated MINOR faults with no instr_retired and require: retries 1 and 2 complete, the 3rd goes IDLE->HALT, fault_irq pulses once, critical_cnt=1 and minor_cnt=3.
REQ-037 The bench SHALL drive two MINOR faults with instr_retired pulsed between them, then a third, and require: no escalation on the third and state=FLUSH.
REQ-038 The bench SHALL drive fault_type=10 during the 2nd FLUSH cycle and require: HALT on the next edge, retry never asserted and critical_cnt=1; then drive clear_fault=1 and require IDLE on the next edge with halted=0.
REQ-039 The bench SHALL drive fault_type=11 in IDLE, then fault_type=01 and clear_fault=0 for 10 cycles, and require: the block stays in HALT and minor_cnt is unchanged.
REQ-040 The bench SHALL drive CNT_W=2 with 5 CRITICAL/clear cycles and require critical_cnt=3 (saturated); it SHALL then assert rst_n=0 mid-HALT and require all outputs 0 asynchronously.

Source files
------------

// File: rtl/fault_response_fsm.sv
// Fault response sequencer: turns classified pipeline faults into
// stall/flush/retry/halt controls, escalating repeated MINOR faults to HALT
// and keeping saturating counts of accepted MINOR events and HALT entries.
module fault_response_fsm #(
    parameter int FLUSH_CYCLES = 3,  // cycles flush is held per MINOR fault (1..15)
    parameter int MAX_RETRY    = 2,  // consecutive MINOR retries before escalation (1..15)
    parameter int CNT_W        = 8   // width of each event counter
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       fault_type,
    input  logic             instr_retired,
    input  logic             clear_fault,
    output logic             stall,
    output logic             flush,
    output logic             retry,
    output logic             halted,
    output logic             fault_irq,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] minor_cnt,
    output logic [CNT_W-1:0] critical_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_FLUSH = 2'b01;
    localparam logic [1:0] ST_RETRY = 2'b10;
    localparam logic [1:0] ST_HALT  = 2'b11;

    localparam int              RW          = $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0]   RETRY_LIMIT = RW'(MAX_RETRY);
    localparam logic [3:0]      FLUSH_LOAD  = 4'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [1:0]       r_state;
    logic [3:0]       r_flush_ctr;
    logic [RW-1:0]    r_retry_cnt;
    logic [CNT_W-1:0] r_minor_cnt;
    logic [CNT_W-1:0] r_critical_cnt;
    logic             r_fault_irq;

    logic [1:0]       w_next_state;
    logic [3:0]       w_next_flush_ctr;
    logic [RW-1:0]    w_next_retry_cnt;
    logic             w_minor_inc;
    logic             w_enter_halt;

    // Next-state and bookkeeping decisions from the current state and inputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        w_next_state     = r_state;
        w_next_flush_ctr = r_flush_ctr;
        w_next_retry_cnt = r_retry_cnt;
        w_minor_inc      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (fault_type[1]) begin
                    // CRITICAL and the reserved code both halt immediately.
                    w_next_state = ST_HALT;
                end else if (fault_type == 2'b01) begin
                    w_minor_inc = 1'b1;
                    if (r_retry_cnt < RETRY_LIMIT) begin
                        w_next_state     = ST_FLUSH;
                        w_next_flush_ctr = FLUSH_LOAD;
                        w_next_retry_cnt = r_retry_cnt + 1'b1;
                    end else begin
                        // Retry budget exhausted: escalate, budget stays at its limit.
                        w_next_state = ST_HALT;
                    end
                end else if (instr_retired) begin
                    // A clean commit proves forward progress; restore the retry budget.
                    w_next_retry_cnt = '0;
                end
            end
            ST_FLUSH: begin
                if (fault_type[1]) begin
                    w_next_state = ST_HALT;
                end else if (r_flush_ctr == 4'd0) begin
                    w_next_state = ST_RETRY;
                end else begin
                    w_next_flush_ctr = r_flush_ctr - 1'b1;
                end
            end
            ST_RETRY: begin
                w_next_state = ST_IDLE;
            end
            default: begin  // ST_HALT
                if (clear_fault) begin
                    w_next_state     = ST_IDLE;
                    w_next_retry_cnt = '0;
                end
            end
        endcase
    end

    assign w_enter_halt = (w_next_state == ST_HALT) && (r_state != ST_HALT);

    // State register, flush/retry bookkeeping and the HALT-entry interrupt pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_flush_ctr <= 4'd0;
            r_retry_cnt <= '0;
            r_fault_irq <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            r_state     <= w_next_state;
            r_flush_ctr <= w_next_flush_ctr;
            r_retry_cnt <= w_next_retry_cnt;
            r_fault_irq <= w_enter_halt;
        end
    end

    // Saturating event counters for accepted MINOR faults and HALT entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_minor_cnt    <= '0;
            r_critical_cnt <= '0;
        end else begin
            if (w_minor_inc && (r_minor_cnt != CNT_MAX))
                r_minor_cnt <= r_minor_cnt + 1'b1;
            if (w_enter_halt && (r_critical_cnt != CNT_MAX))
                r_critical_cnt <= r_critical_cnt + 1'b1;
        end
    end

    // Control outputs are pure decodes of the registered state.
    assign state        = r_state;
    assign stall        = (r_state != ST_IDLE);
    assign flush        = (r_state == ST_FLUSH);
    assign retry        = (r_state == ST_RETRY);
    assign halted       = (r_state == ST_HALT);
    assign fault_irq    = r_fault_irq;
    assign minor_cnt    = r_minor_cnt;
    assign critical_cnt = r_critical_cnt;

endmodule

// File: tb/tb_fault_response_fsm.sv
// Bench for fault_response_fsm: directed scenarios with constant expectations,
// plus a randomized run compared cycle by cycle against a behavioural model.
module tb_fault_response_fsm;

    localparam int F_CYC = 3;
    localparam int M_RTY = 2;
    localparam int SAT8  = 255;

    logic       clk;
    logic       rst_n;
    logic [1:0] fault_type;
    logic       instr_retired;
    logic       clear_fault;
    logic       stall, flush, retry, halted, fault_irq;
    logic [1:0] state;
    logic [7:0] minor_cnt, critical_cnt;

    // Second instance with narrow counters for saturation.
    logic       s_rst_n;
    logic [1:0] s_fault_type;
    logic       s_instr_retired;
    logic       s_clear_fault;
    logic       s_stall, s_flush, s_retry, s_halted, s_fault_irq;
    logic [1:0] s_state;
    logic [1:0] s_minor_cnt, s_critical_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: phase described by remaining flush cycles and flags.
    bit m_halted, m_retry_pending, m_irq;
    int m_flush_left, m_retries, m_minor, m_crit;

    fault_response_fsm #(.FLUSH_CYCLES(F_CYC), .MAX_RETRY(M_RTY), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .fault_type(fault_type),
        .instr_retired(instr_retired), .clear_fault(clear_fault),
        .stall(stall), .flush(flush), .retry(retry), .halted(halted),
        .fault_irq(fault_irq), .state(state),
        .minor_cnt(minor_cnt), .critical_cnt(critical_cnt)
    );

    fault_response_fsm #(.FLUSH_CYCLES(F_CYC), .MAX_RETRY(M_RTY), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(s_rst_n), .fault_type(s_fault_type),
        .instr_retired(s_instr_retired), .clear_fault(s_clear_fault),
        .stall(s_stall), .flush(s_flush), .retry(s_retry), .halted(s_halted),
        .fault_irq(s_fault_irq), .state(s_state),
        .minor_cnt(s_minor_cnt), .critical_cnt(s_critical_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_halted = 0; m_retry_pending = 0; m_irq = 0;
        m_flush_left = 0; m_retries = 0; m_minor = 0; m_crit = 0;
    endtask

    task automatic model_halt();
        m_halted     = 1;
        m_flush_left = 0;
        m_crit       = (m_crit < SAT8) ? m_crit + 1 : SAT8;
        m_irq        = 1;
    endtask

    task automatic model_step();
        m_irq = 0;
        if (m_halted) begin
            if (clear_fault) begin
                m_halted  = 0;
                m_retries = 0;
            end
        end else if (m_flush_left > 0) begin
            if (fault_type[1]) model_halt();
            else begin
                m_flush_left--;
                if (m_flush_left == 0) m_retry_pending = 1;
            end
        end else if (m_retry_pending) begin
            m_retry_pending = 0;
        end else begin
            if (fault_type[1]) model_halt();
            else if (fault_type == 2'b01) begin
                m_minor = (m_minor < SAT8) ? m_minor + 1 : SAT8;
                if (m_retries < M_RTY) begin
                    m_retries++;
                    m_flush_left = F_CYC;
                end else model_halt();
            end else if (instr_retired) m_retries = 0;
        end
    endtask

    function automatic logic [1:0] model_state();
        if (m_halted)              return 2'b11;
        else if (m_flush_left > 0) return 2'b01;
        else if (m_retry_pending)  return 2'b10;
        else                       return 2'b00;
    endfunction

    // One clock: model observes the inputs at the edge, outputs settle 1 ns later.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic apply_reset();
        fault_type = 2'b00; instr_retired = 1'b0; clear_fault = 1'b0;
        s_fault_type = 2'b00; s_instr_retired = 1'b0; s_clear_fault = 1'b0;
        rst_n = 1'b0; s_rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; s_rst_n = 1'b1;
    endtask

    // Stimulus only: one isolated MINOR fault, then wait out flush + retry.
    task automatic minor_fault();
        fault_type = 2'b01; tick();
        fault_type = 2'b00; repeat (F_CYC + 1) tick();
    endtask

    task automatic test_reset();
        fault_type = 2'b00; instr_retired = 1'b0; clear_fault = 1'b0;
        s_fault_type = 2'b00; s_instr_retired = 1'b0; s_clear_fault = 1'b0;
        rst_n = 1'b0; s_rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({state, stall, flush, retry, halted, fault_irq} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b exp=%b", {state, stall, flush, retry, halted, fault_irq}, 7'b0);
        end
        n_checks++;
        if ({minor_cnt, critical_cnt} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_counts got=%h exp=0000", {minor_cnt, critical_cnt});
        end
        @(negedge clk);
        rst_n = 1'b1; s_rst_n = 1'b1;
    endtask

    task automatic test_minor_flush();
        apply_reset();
        fault_type = 2'b01; tick();
        fault_type = 2'b00;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({state, stall, flush, retry} !== 5'b01_110) begin
                n_fail++;
                $display("FAIL minor_flush_cyc%0d got=%b exp=%b", i, {state, stall, flush, retry}, 5'b01_110);
            end
            tick();
        end
        n_checks++;
        if ({state, stall, flush, retry} !== 5'b10_101) begin
            n_fail++;
            $display("FAIL minor_retry got=%b exp=%b", {state, stall, flush, retry}, 5'b10_101);
        end
        tick();
        n_checks++;
        if ({state, stall, flush, retry, halted, minor_cnt} !== {2'b00, 4'b0000, 8'd1}) begin
            n_fail++;
            $display("FAIL minor_idle got state=%0d flags=%b minor=%0d exp state=0 flags=0000 minor=1",
                     state, {stall, flush, retry, halted}, minor_cnt);
        end
    endtask

    task automatic test_escalation();
        int irq_seen;
        apply_reset();
        minor_fault();
        minor_fault();
        n_checks++;
        if ({state, critical_cnt} !== {2'b00, 8'd0}) begin
            n_fail++;
            $display("FAIL esc_two_retries got state=%0d crit=%0d exp state=0 crit=0", state, critical_cnt);
        end
        fault_type = 2'b01; tick(); fault_type = 2'b00;
        n_checks++;
        if ({state, fault_irq, critical_cnt, minor_cnt} !== {2'b11, 1'b1, 8'd1, 8'd3}) begin
            n_fail++;
            $display("FAIL esc_halt got state=%0d irq=%b crit=%0d minor=%0d exp 3 1 1 3",
                     state, fault_irq, critical_cnt, minor_cnt);
        end
        irq_seen = 0;
        repeat (5) begin tick(); if (fault_irq) irq_seen++; end
        n_checks++;
        if (irq_seen != 0 || state !== 2'b11) begin
            n_fail++;
            $display("FAIL esc_irq_once extra_irq=%0d state=%0d exp 0 3", irq_seen, state);
        end
    endtask

    task automatic test_retire_clear();
        apply_reset();
        minor_fault();
        instr_retired = 1'b1; tick(); instr_retired = 1'b0;
        minor_fault();
        fault_type = 2'b01; tick(); fault_type = 2'b00;
        n_checks++;
        if ({state, critical_cnt, minor_cnt} !== {2'b01, 8'd0, 8'd3}) begin
            n_fail++;
            $display("FAIL retire_no_escalate got state=%0d crit=%0d minor=%0d exp 1 0 3",
                     state, critical_cnt, minor_cnt);
        end
        repeat (F_CYC + 1) tick();
        // A fault with a simultaneous commit follows fault rules; budget not restored.
        apply_reset();
        minor_fault();
        minor_fault();
        fault_type = 2'b01; instr_retired = 1'b1; tick();
        fault_type = 2'b00; instr_retired = 1'b0;
        n_checks++;
        if (state !== 2'b11) begin
            n_fail++;
            $display("FAIL retire_same_cycle got state=%0d exp 3", state);
        end
    endtask

    task automatic test_critical_in_flush();
        int retry_seen;
        retry_seen = 0;
        apply_reset();
        fault_type = 2'b01; tick(); if (retry) retry_seen++;
        fault_type = 2'b00; tick(); if (retry) retry_seen++;
        n_checks++;
        if (state !== 2'b01) begin
            n_fail++;
            $display("FAIL crit_flush_2nd got state=%0d exp 1", state);
        end
        fault_type = 2'b10; tick(); if (retry) retry_seen++;
        fault_type = 2'b00;
        n_checks++;
        if ({state, critical_cnt, fault_irq} !== {2'b11, 8'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL crit_flush_halt got state=%0d crit=%0d irq=%b exp 3 1 1", state, critical_cnt, fault_irq);
        end
        repeat (4) begin tick(); if (retry) retry_seen++; end
        n_checks++;
        if (retry_seen != 0) begin
            n_fail++;
            $display("FAIL crit_flush_no_retry got retry_cycles=%0d exp 0", retry_seen);
        end
        clear_fault = 1'b1; tick(); clear_fault = 1'b0;
        n_checks++;
        if ({state, halted} !== 3'b00_0) begin
            n_fail++;
            $display("FAIL crit_clear got state=%0d halted=%b exp 0 0", state, halted);
        end
    endtask

    task automatic test_halt_sticky();
        int bad;
        bad = 0;
        apply_reset();
        fault_type = 2'b11; tick();
        fault_type = 2'b01; clear_fault = 1'b0;
        for (int i = 0; i < 10; i++) begin
            instr_retired = 1'($urandom_range(0, 1));
            tick();
            if (state !== 2'b11 || halted !== 1'b1) bad++;
        end
        fault_type = 2'b00; instr_retired = 1'b0;
        n_checks++;
        if (bad != 0 || minor_cnt !== 8'd0 || critical_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL halt_sticky bad_cycles=%0d minor=%0d crit=%0d exp 0 0 1", bad, minor_cnt, critical_cnt);
        end
        clear_fault = 1'b1; tick(); clear_fault = 1'b0;
        n_checks++;
        if (state !== 2'b00) begin
            n_fail++;
            $display("FAIL halt_release got state=%0d exp 0", state);
        end
    endtask

    task automatic test_reset_abort();
        apply_reset();
        fault_type = 2'b01; tick(); fault_type = 2'b00;
        tick();
        #2 rst_n = 1'b0; model_reset();
        #1;
        n_checks++;
        if ({state, stall, flush, retry, halted, fault_irq, minor_cnt} !== 15'b0) begin
            n_fail++;
            $display("FAIL abort_flush got state=%0d flags=%b minor=%0d exp all 0",
                     state, {stall, flush, retry, halted, fault_irq}, minor_cnt);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({retry, fault_irq, state} !== 4'b0) begin
            n_fail++;
            $display("FAIL abort_held got retry=%b irq=%b state=%0d exp 0 0 0", retry, fault_irq, state);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            s_fault_type = 2'b10; tick(); s_fault_type = 2'b00;
            n_checks++;
            if ({s_state, s_critical_cnt} !== {2'b11, 2'((k + 1 > 3) ? 3 : k + 1)}) begin
                n_fail++;
                $display("FAIL sat_halt%0d got state=%0d crit=%0d exp 3 %0d",
                         k, s_state, s_critical_cnt, (k + 1 > 3) ? 3 : k + 1);
            end
            s_clear_fault = 1'b1; tick(); s_clear_fault = 1'b0;
        end
        s_fault_type = 2'b10; tick(); s_fault_type = 2'b00;
        tick();
        n_checks++;
        if ({s_halted, s_critical_cnt} !== 3'b1_11) begin
            n_fail++;
            $display("FAIL sat_final got halted=%b crit=%0d exp 1 3", s_halted, s_critical_cnt);
        end
        #3 s_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({s_state, s_stall, s_flush, s_retry, s_halted, s_fault_irq, s_minor_cnt, s_critical_cnt} !== 11'b0) begin
            n_fail++;
            $display("FAIL sat_async_reset got state=%0d flags=%b crit=%0d exp all 0",
                     s_state, {s_stall, s_flush, s_retry, s_halted, s_fault_irq}, s_critical_cnt);
        end
        @(negedge clk); s_rst_n = 1'b1;
    endtask

    task automatic test_random();
        int r;
        logic [1:0] es;
        int shown;
        shown = 0;
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 9);
            fault_type    = (r < 6) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
            instr_retired = ($urandom_range(0, 3) == 0);
            clear_fault   = ($urandom_range(0, 5) == 0);
            tick();
            es = model_state();
            n_checks++;
            if ({state, stall, flush, retry, halted, fault_irq} !==
                {es, es != 2'b00, es == 2'b01, es == 2'b10, es == 2'b11, m_irq}) begin
                n_fail++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL rand_ctrl cyc%0d got state=%0d flags=%b exp state=%0d irq=%b",
                             c, state, {stall, flush, retry, halted, fault_irq}, es, m_irq);
                end
            end
            n_checks++;
            if (minor_cnt !== 8'(m_minor) || critical_cnt !== 8'(m_crit)) begin
                n_fail++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL rand_counts cyc%0d got minor=%0d crit=%0d exp %0d %0d",
                             c, minor_cnt, critical_cnt, m_minor, m_crit);
                end
            end
        end
        fault_type = 2'b00; instr_retired = 1'b0; clear_fault = 1'b0;
    endtask

    initial begin
        test_reset();
        test_minor_flush();
        test_escalation();
        test_retire_clear();
        test_critical_in_flush();
        test_halt_sticky();
        test_reset_abort();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
